// File: rtl/acc_frame_pkg.sv
// Shared types and default sizing for the acc_frame operand accumulator.
package acc_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_COUNT = 4;

endpackage

// File: rtl/acc_frame_beat_counter.sv
// Operand counter for one frame: clear, increment, and a terminal flag that is
// high while the next accept will be the last operand of the frame.
module beat_counter
  import acc_frame_pkg::*;
#(
  parameter int COUNT = DEF_COUNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);

  logic [7:0] cnt_q, cnt_d;

  // Clear wins over increment so a completed frame always restarts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == 8'(COUNT - 1));

endmodule

// File: rtl/acc_frame.sv
// Accumulates COUNT unsigned operands per frame and presents the sum with a
// sticky carry flag. Define ACC_FRAME_SATURATE_EN to saturate instead of wrap.
module acc_frame
  import acc_frame_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int COUNT = DEF_COUNT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:0] out_sum,
  output logic           out_ovf,
  output logic           busy
);

  state_e           state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH+1:0] sum;
  logic             accept;
  logic             term;
  logic             clr;

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

  assign accept = in_valid && in_ready;
  assign clr    = (state_q == DONE) && out_ready;
  assign sum    = {1'b0, acc_q} + {1'b0, in_data};

  beat_counter #(.COUNT(COUNT)) u_beat_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .inc_i  (accept),
    .term_o (term)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = in_data;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          ovf_d = ovf_q | sum[WIDTH+1];
`ifdef ACC_FRAME_SATURATE_EN
          // Sticky ovf keeps the accumulator pinned for the rest of the frame.
          acc_d = ovf_d ? '1 : sum[WIDTH:0];
`else
          acc_d = sum[WIDTH:0];
`endif
          if (term) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_acc_frame.sv
// Directed bench for acc_frame: expected frame results are queued when the
// last operand is driven and compared when the output handshake occurs.
module tb_acc_frame;

  localparam int W = 4;
  localparam int C = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W:0]   in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_sum;
  logic         out_ovf;
  logic         busy;

  int numChecks;
  int numFails;

  logic [W+1:0] sbQ[$];

  acc_frame #(.WIDTH(W), .COUNT(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of one frame: returns {ovf, sum}.
  function automatic logic [W+1:0] modelFrame(input int a, input int b, input int c, input int d);
    int ops[4];
    int acc;
    logic ovf;
    ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = d;
    acc = ops[0];
    ovf = 1'b0;
    for (int i = 1; i < 4; i++) begin
      acc = acc + ops[i];
      if (acc >= (1 << (W + 1))) begin
        ovf = 1'b1;
`ifdef ACC_FRAME_SATURATE_EN
        acc = (1 << (W + 1)) - 1;
`else
        acc = acc - (1 << (W + 1));
`endif
      end
`ifdef ACC_FRAME_SATURATE_EN
      if (ovf) acc = (1 << (W + 1)) - 1;
`endif
    end
    return {ovf, acc[W:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    assert (observed === expected) else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, pass the rising edge, settle just after it.
  task automatic applyStimulus(input logic v, input logic [W:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Result checker on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          logic [W+1:0] exp;
          exp = sbQ.pop_front();
          checkOutput("frame_sum", 32'(out_sum), 32'(exp[W:0]));
          checkOutput("frame_ovf", 32'(out_ovf), 32'(exp[W+1]));
        end
      end else if (sbQ.size() == 0) begin
        checkOutput("no_result_pending", 32'(out_valid), 32'd0);
      end
    end
  end

  initial begin
    numChecks = 0;
    numFails  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_sum", 32'(out_sum), 32'd0);
    checkOutput("rst_out_ovf", 32'(out_ovf), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    $display("[TB] back-to-back frame 3,5,7,9");
    applyStimulus(1'b1, 5'd3, 1'b1);
    applyStimulus(1'b1, 5'd5, 1'b1);
    applyStimulus(1'b1, 5'd7, 1'b1);
    checkOutput("b2b_no_early_valid", 32'(out_valid), 32'd0);
    sbQ.push_back(modelFrame(3, 5, 7, 9));
    applyStimulus(1'b1, 5'd9, 1'b1);
    checkOutput("b2b_latency_valid", 32'(out_valid), 32'd1);
    checkOutput("b2b_done_in_ready", 32'(in_ready), 32'd0);
    checkOutput("b2b_done_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("b2b_idle_valid", 32'(out_valid), 32'd0);
    checkOutput("b2b_idle_busy", 32'(busy), 32'd0);
    checkOutput("b2b_cleared_sum", 32'(out_sum), 32'd0);

    $display("[TB] overflow frame 20,20,1,1");
    applyStimulus(1'b1, 5'd20, 1'b1);
    applyStimulus(1'b1, 5'd20, 1'b1);
    applyStimulus(1'b1, 5'd1, 1'b1);
    sbQ.push_back(modelFrame(20, 20, 1, 1));
    applyStimulus(1'b1, 5'd1, 1'b1);
`ifdef ACC_FRAME_SATURATE_EN
    checkOutput("ovf_sum_const", 32'(out_sum), 32'd31);
`else
    checkOutput("ovf_sum_const", 32'(out_sum), 32'd10);
`endif
    checkOutput("ovf_flag_const", 32'(out_ovf), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);

    $display("[TB] backpressure in DONE");
    applyStimulus(1'b1, 5'd3, 1'b0);
    applyStimulus(1'b1, 5'd5, 1'b0);
    applyStimulus(1'b1, 5'd7, 1'b0);
    sbQ.push_back(modelFrame(3, 5, 7, 9));
    applyStimulus(1'b1, 5'd9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 5'd7, 1'b0);
      checkOutput("stall_sum", 32'(out_sum), 32'd24);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_valid", 32'(out_valid), 32'd1);
    end
    applyStimulus(1'b1, 5'd7, 1'b1);
    checkOutput("stall_release_busy", 32'(busy), 32'd0);
    checkOutput("stall_release_sum", 32'(out_sum), 32'd0);
    applyStimulus(1'b1, 5'd1, 1'b1);
    applyStimulus(1'b1, 5'd1, 1'b1);
    applyStimulus(1'b1, 5'd1, 1'b1);
    sbQ.push_back(modelFrame(1, 1, 1, 1));
    applyStimulus(1'b1, 5'd1, 1'b1);
    checkOutput("ones_sum_const", 32'(out_sum), 32'd4);
    applyStimulus(1'b0, '0, 1'b1);

    $display("[TB] gapped frame 3,5,7,9");
    applyStimulus(1'b1, 5'd3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("gap_busy", 32'(busy), 32'd1);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("gap_busy", 32'(busy), 32'd1);
      if (k == 2) sbQ.push_back(modelFrame(3, 5, 7, 9));
      applyStimulus(1'b1, (k == 0) ? 5'd5 : ((k == 1) ? 5'd7 : 5'd9), 1'b1);
    end
    checkOutput("gap_valid", 32'(out_valid), 32'd1);
    checkOutput("gap_sum_const", 32'(out_sum), 32'd24);
    applyStimulus(1'b0, '0, 1'b1);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 5'd5, 1'b1);
    applyStimulus(1'b1, 5'd6, 1'b1);
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b1);
    rst_n = 1'b1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_sum", 32'(out_sum), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 5'd2, 1'b1);
    applyStimulus(1'b1, 5'd2, 1'b1);
    applyStimulus(1'b1, 5'd2, 1'b1);
    sbQ.push_back(modelFrame(2, 2, 2, 2));
    applyStimulus(1'b1, 5'd2, 1'b1);
    checkOutput("twos_sum_const", 32'(out_sum), 32'd8);
    checkOutput("twos_ovf_const", 32'(out_ovf), 32'd0);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);

    checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
